// File: rtl/ring_router_mux_rr.sv
// N-input worm-preserving flit multiplexer: fixed-priority or round-robin arbitration,
// packets never interleaved, optional registered output stage.
module ring_router_mux_rr #(
    parameter int NUM_IN     = 2,
    parameter int DATA_WIDTH = 16,
    parameter int ARB_MODE   = 0,
    parameter int OUT_REG    = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]            in_last,
    input  logic [NUM_IN-1:0]            in_valid,
    output logic [NUM_IN-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy
);
    localparam int IDX_W = $clog2(NUM_IN);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [IDX_W-1:0]      winner;
    logic                  any_valid;
    logic [IDX_W-1:0]      sel;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  stage_ready;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] ch_data [NUM_IN];

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_unpack
        assign ch_data[gi] = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Scan from the highest search offset down so the lowest offset (highest priority) wins.
    always_comb begin
        int idx;
        idx       = 0;
        winner    = '0;
        any_valid = 1'b0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            idx = (ARB_MODE == 0) ? k : (int'(rr_ptr_q) + k) % NUM_IN;
            if (in_valid[idx]) begin
                winner    = IDX_W'(idx);
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        sel       = (state_q == LOCKED) ? grant_q : winner;
        sel_valid = !rst && ((state_q == LOCKED) ? in_valid[sel] : any_valid);
        sel_data  = ch_data[sel];
        sel_last  = in_last[sel];
        in_ready  = '0;
        if (!rst && (state_q == LOCKED || any_valid)) begin
            in_ready[sel] = stage_ready;
        end
        xfer = sel_valid && stage_ready;
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (!sel_last) begin
                        state_d = LOCKED;
                        grant_d = winner;
                    end
                    if (ARB_MODE != 0) begin
                        rr_ptr_d = (winner == IDX_W'(NUM_IN - 1)) ? '0 : winner + 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (xfer && sel_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign busy = (state_q == LOCKED);

    if (OUT_REG != 0) begin : g_out_reg
        logic                  out_valid_q, out_valid_d;
        logic                  out_last_q, out_last_d;
        logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

        always_comb begin
            out_valid_d = out_valid_q;
            out_last_d  = out_last_q;
            out_data_d  = out_data_q;
            if (xfer) begin
                out_valid_d = 1'b1;
                out_last_d  = sel_last;
                out_data_d  = sel_data;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
                out_data_q  <= '0;
            end else begin
                out_valid_q <= out_valid_d;
                out_last_q  <= out_last_d;
                out_data_q  <= out_data_d;
            end
        end

        assign stage_ready = !out_valid_q || out_ready;
        assign out_valid   = out_valid_q;
        assign out_last    = out_last_q;
        assign out_data    = out_data_q;
    end else begin : g_out_comb
        assign stage_ready = out_ready;
        assign out_valid   = sel_valid;
        assign out_last    = sel_last;
        assign out_data    = sel_data;
    end
endmodule

// File: tb/tb_ring_router_mux_rr.sv
// Bench for ring_router_mux_rr: four NUM_IN=5 instances covering both arbitration modes and
// both output-stage options, driven from per-channel flit queues and a packet-level model.
`timescale 1ns/1ps
module tb_ring_router_mux_rr;
    localparam int N  = 5;
    localparam int W  = 16;
    localparam int NI = 4;   // instance d: ARB_MODE = d/2, OUT_REG = d%2

    typedef struct {
        logic [W-1:0] data;
        logic         last;
        int           dly;
    } flit_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] in_data   [NI];
    logic [N-1:0]   in_last   [NI];
    logic [N-1:0]   in_valid  [NI];
    logic [N-1:0]   in_ready  [NI];
    logic [W-1:0]   out_data  [NI];
    logic           out_last  [NI];
    logic           out_valid [NI];
    logic           out_ready [NI];
    logic           busy      [NI];

    int         vectors     = 0;
    int         miscompares = 0;
    flit_t      txq [N][$];
    logic [W:0] out_log [$];
    logic [W:0] in_log [$];
    logic [W:0] exp_q [$];
    int         rr_next [NI];
    int         max_wait;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        ring_router_mux_rr #(
            .NUM_IN    (N),
            .DATA_WIDTH(W),
            .ARB_MODE  (gi / 2),
            .OUT_REG   (gi % 2)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_data  (in_data[gi]),
            .in_last  (in_last[gi]),
            .in_valid (in_valid[gi]),
            .in_ready (in_ready[gi]),
            .out_data (out_data[gi]),
            .out_last (out_last[gi]),
            .out_valid(out_valid[gi]),
            .out_ready(out_ready[gi]),
            .busy     (busy[gi])
        );
    end

    // Flit tag: channel, packet number, flit index within packet.
    function automatic logic [W-1:0] mk(input int ch, input int pkt, input int fl);
        logic [3:0] c4;
        logic [7:0] p8;
        logic [3:0] f4;
        c4 = 4'(ch);
        p8 = 8'(pkt);
        f4 = 4'(fl);
        return {c4, p8, f4};
    endfunction

    task automatic add_flit(input int ch, input logic [W-1:0] data, input logic last, input int dly);
        flit_t f;
        f.data = data;
        f.last = last;
        f.dly  = dly;
        txq[ch].push_back(f);
    endtask

    task automatic add_pkt(input int ch, input int pkt, input int len, input int dly0, input int gap_max);
        for (int f = 0; f < len; f++) begin
            add_flit(ch, mk(ch, pkt, f), 1'(f == len - 1), (f == 0) ? dly0 : int'($urandom_range(0, gap_max)));
        end
    endtask

    // Drives instance d from txq until all queued flits have left the output, checking every
    // cycle against the packet-level model (who may be granted, what must appear at the output).
    task automatic run(input int d, input int rmode, input int budget, output int cycles);
        int         arb, oreg, sel, worm, c2;
        logic       pending, ov_m, stg, rdy, xf, exp_ov, prev_stall;
        logic [N-1:0] pres, exp_rdy;
        logic [W:0] od_m, exp_od, prev_out, got;
        flit_t      cur [N];
        flit_t      h;
        int         wait_cnt [N];
        arb = d / 2;
        oreg = d % 2;
        worm = -1;
        pres = '0;
        ov_m = 1'b0;
        od_m = '0;
        prev_stall = 1'b0;
        prev_out = '0;
        max_wait = 0;
        cycles = 0;
        for (int c = 0; c < N; c++) wait_cnt[c] = 0;
        forever begin
            pending = (pres != '0) || ov_m;
            for (int c = 0; c < N; c++) if (txq[c].size() != 0) pending = 1'b1;
            if (!pending) break;
            if (cycles >= budget) begin
                vectors++;
                miscompares++;
                $display("FAIL timeout d=%0d got=%0d cycles required<%0d", d, cycles, budget);
                for (int c = 0; c < N; c++) txq[c].delete();
                break;
            end
            for (int c = 0; c < N; c++) begin
                if (!pres[c] && txq[c].size() != 0) begin
                    if (txq[c][0].dly > 0) begin
                        h = txq[c][0];
                        h.dly--;
                        txq[c][0] = h;
                    end else begin
                        cur[c] = txq[c].pop_front();
                        pres[c] = 1'b1;
                    end
                end
                in_valid[d][c] = pres[c];
                in_data[d][c*W +: W] = pres[c] ? cur[c].data : W'($urandom);
                in_last[d][c] = pres[c] ? cur[c].last : 1'($urandom);
            end
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 99) < 70);
                default: rdy = (cycles % 4 == 0) || (cycles % 4 == 3);
            endcase
            out_ready[d] = rdy;
            #4;
            sel = worm;
            if (worm < 0) begin
                for (int k = N - 1; k >= 0; k--) begin
                    c2 = (arb != 0) ? (rr_next[d] + k) % N : k;
                    if (pres[c2]) sel = c2;
                end
            end
            stg = (oreg != 0) ? (!ov_m || rdy) : rdy;
            exp_rdy = '0;
            if (sel >= 0) exp_rdy[sel] = stg;
            vectors++;
            if (in_ready[d] !== exp_rdy) begin
                miscompares++;
                $display("FAIL in_ready d=%0d cyc=%0d got=%b exp=%b", d, cycles, in_ready[d], exp_rdy);
            end
            vectors++;
            if (busy[d] !== 1'(worm >= 0)) begin
                miscompares++;
                $display("FAIL busy d=%0d cyc=%0d got=%b exp=%b", d, cycles, busy[d], worm >= 0);
            end
            exp_ov = (oreg != 0) ? ov_m : (sel >= 0 && pres[sel]);
            vectors++;
            if (out_valid[d] !== exp_ov) begin
                miscompares++;
                $display("FAIL out_valid d=%0d cyc=%0d got=%b exp=%b", d, cycles, out_valid[d], exp_ov);
            end
            got = {out_last[d], out_data[d]};
            if (exp_ov) begin
                exp_od = (oreg != 0) ? od_m : {cur[sel].last, cur[sel].data};
                vectors++;
                if (got !== exp_od) begin
                    miscompares++;
                    $display("FAIL out_flit d=%0d cyc=%0d got=%h exp=%h", d, cycles, got, exp_od);
                end
            end
            if (oreg != 0 && prev_stall) begin
                vectors++;
                if (got !== prev_out) begin
                    miscompares++;
                    $display("FAIL stall_hold d=%0d cyc=%0d got=%h exp=%h", d, cycles, got, prev_out);
                end
            end
            prev_stall = (out_valid[d] === 1'b1) && !rdy;
            prev_out = got;
            if (out_valid[d] === 1'b1 && rdy) out_log.push_back(got);
            xf = (sel >= 0) && pres[sel] && stg;
            if (oreg != 0) begin
                if (xf) begin
                    ov_m = 1'b1;
                    od_m = {cur[sel].last, cur[sel].data};
                end else if (rdy) begin
                    ov_m = 1'b0;
                end
            end
            if (xf) begin
                in_log.push_back({cur[sel].last, cur[sel].data});
                if (worm < 0) begin
                    if (arb != 0) begin
                        for (int c = 0; c < N; c++) begin
                            if (c != sel && pres[c]) begin
                                wait_cnt[c]++;
                                if (wait_cnt[c] > max_wait) max_wait = wait_cnt[c];
                            end
                        end
                        wait_cnt[sel] = 0;
                        rr_next[d] = (sel + 1) % N;
                    end
                    if (!cur[sel].last) worm = sel;
                end else if (cur[sel].last) begin
                    worm = -1;
                end
                pres[sel] = 1'b0;
            end
            cycles++;
            @(negedge clk);
        end
        in_valid[d] = '0;
        out_ready[d] = 1'b1;
        vectors++;
        if (out_log.size() != in_log.size()) begin
            miscompares++;
            $display("FAIL flit_count d=%0d got=%0d exp=%0d", d, out_log.size(), in_log.size());
        end
        for (int i = 0; i < out_log.size() && i < in_log.size(); i++) begin
            vectors++;
            if (out_log[i] !== in_log[i]) begin
                miscompares++;
                $display("FAIL stream d=%0d idx=%0d got=%h exp=%h", d, i, out_log[i], in_log[i]);
            end
        end
        if (arb != 0) begin
            vectors++;
            if (max_wait > N - 1) begin
                miscompares++;
                $display("FAIL rr_starvation d=%0d got=%0d exp<=%0d", d, max_wait, N - 1);
            end
        end
        $display("run d=%0d flits=%0d cycles=%0d", d, out_log.size(), cycles);
    endtask

    task automatic check_expected(input string name, input int d);
        vectors++;
        if (out_log.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL %s_len d=%0d got=%0d exp=%0d", name, d, out_log.size(), exp_q.size());
        end
        for (int i = 0; i < out_log.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (out_log[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL %s d=%0d idx=%0d got=%h exp=%h", name, d, i, out_log[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < NI; d++) rr_next[d] = 0;
        #1;
        for (int d = 0; d < NI; d++) begin
            vectors++;
            if (out_valid[d] !== 1'b0 || busy[d] !== 1'b0 || in_ready[d] !== '0) begin
                miscompares++;
                $display("FAIL reset_state d=%0d got=%b%b%b exp=000", d, out_valid[d], busy[d], |in_ready[d]);
            end
        end
        @(negedge clk);
        for (int d = 0; d < NI; d++) begin
            in_valid[d] = '1;
            in_last[d]  = '0;
            in_data[d]  = {N{16'h5a5a}};
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < NI; d++) begin
            vectors++;
            if (busy[d] !== 1'b1) begin
                miscompares++;
                $display("FAIL lock_before_reset d=%0d got=%b exp=1", d, busy[d]);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        for (int d = 0; d < NI; d++) begin
            vectors++;
            if (out_valid[d] !== 1'b0 || busy[d] !== 1'b0 || in_ready[d] !== '0) begin
                miscompares++;
                $display("FAIL async_reset d=%0d got=%b%b%b exp=000", d, out_valid[d], busy[d], |in_ready[d]);
            end
        end
        @(negedge clk);
        for (int d = 0; d < NI; d++) in_valid[d] = '0;
        rst = 1'b0;
        $display("reset checked on %0d instances", NI);
    endtask

    task automatic test_fixed_prio();
        int cyc;
        for (int d = 0; d < 2; d++) begin
            out_log.delete();
            in_log.delete();
            add_pkt(0, 0, 3, 0, 0);
            add_pkt(2, 0, 3, 0, 0);
            run(d, 0, 200, cyc);
            exp_q.delete();
            for (int f = 0; f < 3; f++) exp_q.push_back({1'(f == 2), mk(0, 0, f)});
            for (int f = 0; f < 3; f++) exp_q.push_back({1'(f == 2), mk(2, 0, f)});
            check_expected("fixed_order", d);
        end
    endtask

    task automatic test_rr_order();
        int cyc;
        for (int d = 2; d < 4; d++) begin
            out_log.delete();
            in_log.delete();
            for (int c = 0; c < N; c++) begin
                for (int n = 0; n < 4; n++) add_flit(c, mk(c, n, 0), 1'b1, 0);
            end
            run(d, 0, 200, cyc);
            exp_q.delete();
            for (int n = 0; n < 4; n++) begin
                for (int c = 0; c < N; c++) exp_q.push_back({1'b1, mk(c, n, 0)});
            end
            check_expected("rr_order", d);
            vectors++;
            if (cyc != 4 * N + d % 2) begin
                miscompares++;
                $display("FAIL rr_throughput d=%0d got=%0d cycles exp=%0d", d, cyc, 4 * N + d % 2);
            end
        end
    endtask

    task automatic test_bubble();
        int cyc;
        for (int d = 0; d < 2; d++) begin
            out_log.delete();
            in_log.delete();
            add_flit(1, mk(1, 0, 0), 1'b0, 0);
            add_flit(1, mk(1, 0, 1), 1'b0, 0);
            add_flit(1, mk(1, 0, 2), 1'b0, 2);
            add_flit(1, mk(1, 0, 3), 1'b1, 0);
            add_pkt(0, 0, 2, 1, 0);
            run(d, 0, 200, cyc);
            exp_q.delete();
            for (int f = 0; f < 4; f++) exp_q.push_back({1'(f == 3), mk(1, 0, f)});
            for (int f = 0; f < 2; f++) exp_q.push_back({1'(f == 1), mk(0, 0, f)});
            check_expected("bubble", d);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        for (int d = 0; d < 2; d++) begin
            out_log.delete();
            in_log.delete();
            add_pkt(3, 0, 5, 0, 0);
            add_pkt(4, 0, 3, 0, 0);
            add_pkt(0, 0, 1, 0, 0);
            run(d, 2, 300, cyc);
            exp_q.delete();
            exp_q.push_back({1'b1, mk(0, 0, 0)});
            for (int f = 0; f < 5; f++) exp_q.push_back({1'(f == 4), mk(3, 0, f)});
            for (int f = 0; f < 3; f++) exp_q.push_back({1'(f == 2), mk(4, 0, f)});
            check_expected("backpressure", d);
        end
    endtask

    task automatic test_random();
        int cyc, pos, ch, pk;
        int lens [N][6];
        int next_pkt [N];
        logic [W-1:0] data;
        logic lst;
        for (int d = 0; d < NI; d++) begin
            out_log.delete();
            in_log.delete();
            for (int c = 0; c < N; c++) begin
                for (int p = 0; p < 6; p++) begin
                    lens[c][p] = $urandom_range(1, 4);
                    add_pkt(c, p, lens[c][p], $urandom_range(0, 3), 2);
                end
                next_pkt[c] = 0;
            end
            run(d, 1, 3000, cyc);
            pos = 0;
            ch = 0;
            pk = 0;
            for (int i = 0; i < out_log.size(); i++) begin
                data = out_log[i][W-1:0];
                lst  = out_log[i][W];
                vectors++;
                if (pos == 0) begin
                    ch = int'(data[15:12]);
                    pk = int'(data[11:4]);
                    if (ch >= N || pk != next_pkt[ch]) begin
                        miscompares++;
                        $display("FAIL pkt_order d=%0d idx=%0d got=%h exp_pkt=%0d", d, i, data,
                                 (ch < N) ? next_pkt[ch] : -1);
                    end
                end else if (int'(data[15:12]) != ch || int'(data[11:4]) != pk) begin
                    miscompares++;
                    $display("FAIL interleave d=%0d idx=%0d got=%h exp_ch=%0d exp_pkt=%0d", d, i, data, ch, pk);
                end
                vectors++;
                if (int'(data[3:0]) != pos) begin
                    miscompares++;
                    $display("FAIL flit_seq d=%0d idx=%0d got=%0d exp=%0d", d, i, data[3:0], pos);
                end
                if (ch < N && pk < 6) begin
                    vectors++;
                    if (lst !== 1'(pos == lens[ch][pk] - 1)) begin
                        miscompares++;
                        $display("FAIL last_flag d=%0d idx=%0d got=%b exp=%b", d, i, lst, pos == lens[ch][pk] - 1);
                    end
                end
                if (lst) begin
                    pos = 0;
                    if (ch < N) next_pkt[ch]++;
                end else begin
                    pos++;
                end
            end
            for (int c = 0; c < N; c++) begin
                vectors++;
                if (next_pkt[c] != 6) begin
                    miscompares++;
                    $display("FAIL delivered d=%0d ch=%0d got=%0d exp=6", d, c, next_pkt[c]);
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < NI; d++) begin
            in_data[d]   = '0;
            in_last[d]   = '0;
            in_valid[d]  = '0;
            out_ready[d] = 1'b1;
        end
        rst = 1'b1;
        test_reset();
        test_fixed_prio();
        test_rr_order();
        test_bubble();
        test_backpressure();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
